// File: rtl/key_event_decoder.sv
// PS/2 scan-code decoder: turns the raw byte stream into a held-key bitmap,
// the last changed key code and a one-cycle event strobe for the game logic.
module key_event_decoder #(
   parameter int unsigned TIMEOUT_CYCLES  = 100000,
   parameter bit          REPEAT_SUPPRESS = 1'b1,
   parameter int unsigned COUNT_W         = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   input  logic         flush,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         key_valid,
   output logic         seq_error
);

   typedef enum logic [2:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0,
      SKIP
   } state_t;

   localparam logic [COUNT_W-1:0] TMO_LIMIT = COUNT_W'(TIMEOUT_CYCLES);
   localparam logic [2:0]         PAUSE_LEN = 3'd7;

   state_t             state, state_nxt;
   logic [2:0]         skip_cnt, skip_nxt;
   logic [COUNT_W-1:0] tmo_cnt, tmo_nxt;
   logic               ev_make, ev_break, overrun, timeout;
   logic               make_hit;
   logic [8:0]         ev_code;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      tmo_nxt   = tmo_cnt;
      ev_make   = 1'b0;
      ev_break  = 1'b0;
      ev_code   = '0;
      overrun   = 1'b0;
      timeout   = 1'b0;

      if (rx_valid) begin
         tmo_nxt = '0;
         unique case (state)
            IDLE: begin
               case (rx_data)
                  8'hE0: state_nxt = GOT_E0;
                  8'hF0: state_nxt = GOT_F0;
                  8'hE1: begin
                     state_nxt = SKIP;
                     skip_nxt  = PAUSE_LEN;
                  end
                  8'hFA, 8'hFE, 8'hEE, 8'hAA: ;
                  8'h00, 8'hFF: overrun = 1'b1;
                  default: begin
                     ev_make = 1'b1;
                     ev_code = {1'b0, rx_data};
                  end
               endcase
            end
            GOT_E0: begin
               case (rx_data)
                  8'hF0: state_nxt = GOT_E0F0;
                  8'hE0: state_nxt = GOT_E0;
                  8'h12: state_nxt = IDLE;
                  default: begin
                     state_nxt = IDLE;
                     ev_make   = 1'b1;
                     ev_code   = {1'b1, rx_data};
                  end
               endcase
            end
            GOT_F0: begin
               state_nxt = IDLE;
               ev_break  = 1'b1;
               ev_code   = {1'b0, rx_data};
            end
            GOT_E0F0: begin
               state_nxt = IDLE;
               if (rx_data != 8'h12) begin
                  ev_break = 1'b1;
                  ev_code  = {1'b1, rx_data};
               end
            end
            SKIP: begin
               skip_nxt = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE) begin
         // Leaving the sequence on the limit keeps the counter saturated there.
         if (tmo_cnt == TMO_LIMIT - COUNT_W'(1)) begin
            tmo_nxt   = TMO_LIMIT;
            state_nxt = IDLE;
            skip_nxt  = '0;
            timeout   = 1'b1;
         end else begin
            tmo_nxt = tmo_cnt + COUNT_W'(1);
         end
      end
   end

   // Typematic repeats of a held key are dropped silently when suppression is on.
   assign make_hit = ev_make && !(REPEAT_SUPPRESS && key_down[ev_code]);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         skip_cnt    <= '0;
         tmo_cnt     <= '0;
         key_down    <= '0;
         last_change <= '0;
         key_valid   <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         seq_error <= 1'b0;
         if (flush) begin
            state    <= IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
            key_down <= '0;
         end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_nxt;
            tmo_cnt   <= tmo_nxt;
            seq_error <= overrun | timeout;
            if (overrun) key_down <= '0;
            if (make_hit) begin
               key_down[ev_code] <= 1'b1;
               last_change       <= ev_code;
               key_valid         <= 1'b1;
            end
            if (ev_break) begin
               key_down[ev_code] <= 1'b0;
               last_change       <= ev_code;
               key_valid         <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: two instances (repeat suppression on/off) run the
// same byte stream against a prefix-flag reference model, cycle by cycle.
module tb_key_event_decoder;

   localparam int TMO = 40;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         rx_valid = 1'b0;
   logic         flush = 1'b0;
   logic [511:0] kd_s, kd_n;
   logic [8:0]   lc_s, lc_n;
   logic         kv_s, kv_n, se_s, se_n;

   int n_vec = 0;
   int n_err = 0;

   key_event_decoder #(.TIMEOUT_CYCLES(TMO), .REPEAT_SUPPRESS(1'b1), .COUNT_W(8)) dut_s (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
      .key_down(kd_s), .last_change(lc_s), .key_valid(kv_s), .seq_error(se_s));

   key_event_decoder #(.TIMEOUT_CYCLES(TMO), .REPEAT_SUPPRESS(1'b0), .COUNT_W(8)) dut_n (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
      .key_down(kd_n), .last_change(lc_n), .key_valid(kv_n), .seq_error(se_n));

   always #5 clk = ~clk;

   // Reference model: index 0 = suppressing instance, 1 = non-suppressing.
   logic [511:0] m_held [2];
   logic [8:0]   m_last [2];
   logic         e_kv   [2];
   logic         e_se;
   bit           m_ext, m_brk;
   int           m_skip, m_quiet;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_held[i] = '0;
         m_last[i] = '0;
         e_kv[i]   = 1'b0;
      end
      e_se = 1'b0; m_ext = 0; m_brk = 0; m_skip = 0; m_quiet = 0;
   endtask

   task automatic model_key(input bit is_make, input logic [8:0] code);
      for (int i = 0; i < 2; i++) begin
         if (!(is_make && i == 0 && m_held[i][code])) begin
            m_held[i][code] = is_make;
            m_last[i]       = code;
            e_kv[i]         = 1'b1;
         end
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
      end else if (!m_ext && !m_brk) begin
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE1) m_skip = 7;
         else if (b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'hAA) ;
         else if (b == 8'h00 || b == 8'hFF) begin
            m_held[0] = '0; m_held[1] = '0; e_se = 1'b1;
         end else model_key(1, {1'b0, b});
      end else if (m_ext && !m_brk && b == 8'hF0) begin
         m_brk = 1;
      end else if (m_ext && !m_brk && b == 8'hE0) begin
         ;
      end else begin
         if (!(m_ext && b == 8'h12)) model_key(!m_brk, {m_ext, b});
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_cycle(input bit v, input logic [7:0] b, input bit fl);
      e_kv[0] = 1'b0; e_kv[1] = 1'b0; e_se = 1'b0;
      if (fl) begin
         m_held[0] = '0; m_held[1] = '0;
         m_ext = 0; m_brk = 0; m_skip = 0; m_quiet = 0;
      end else if (v) begin
         m_quiet = 0;
         model_byte(b);
      end else if (m_ext || m_brk || m_skip > 0) begin
         m_quiet++;
         if (m_quiet == TMO) begin
            m_ext = 0; m_brk = 0; m_skip = 0; e_se = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check("kv_s", 512'(kv_s), 512'(e_kv[0]));
      check("kv_n", 512'(kv_n), 512'(e_kv[1]));
      check("se_s", 512'(se_s), 512'(e_se));
      check("se_n", 512'(se_n), 512'(e_se));
      check("lc_s", 512'(lc_s), 512'(m_last[0]));
      check("lc_n", 512'(lc_n), 512'(m_last[1]));
      check("kd_s", kd_s, m_held[0]);
      check("kd_n", kd_n, m_held[1]);
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit fl);
      @(negedge clk);
      rx_valid = v; rx_data = b; flush = fl;
      @(posedge clk);
      model_cycle(v, b, fl);
      #1 compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      step(1, b, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0);
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 11))
         0: return 8'hE0;
         1: return 8'hF0;
         2: return 8'hE1;
         3: return 8'h12;
         4: return 8'h1C;
         5: return 8'h29;
         6: return 8'h75;
         7: return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         8: return 8'hFA;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      model_reset();
      #2 compare_all();
      @(negedge clk) rst = 1'b1;

      // Make and break of a plain key.
      send(8'h1C); idle(1);
      send(8'hF0); send(8'h1C); idle(1);
      // Typematic repeats.
      send(8'h1C); send(8'h1C); send(8'h1C); idle(1);
      send(8'hF0); send(8'h1C);
      // Extended make/break and fake shift.
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h12); idle(2);
      // Timeout abandons E0; the next byte is a plain make.
      send(8'hE0); idle(TMO + 3);
      send(8'h29); idle(1);
      check("ext_not_set", 512'(kd_s[9'h129]), 512'(1'b0));
      check("plain_set", 512'(kd_s[9'h029]), 512'(1'b1));
      // Overrun clears held keys.
      send(8'h1C); send(8'h00); idle(1);
      // Flush wins over a simultaneous byte.
      send(8'h1C); step(1, 8'h1C, 1); idle(1);
      // Pause sequence produces no events.
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C); idle(1);
      // Asynchronous reset mid-sequence.
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
      #2 rst = 1'b0;
      rx_valid = 1'b0;
      model_reset();
      #1 compare_all();
      @(negedge clk) rst = 1'b1;
      send(8'h1C); idle(1);
      check("post_rst_make", 512'(lc_n), 512'(9'h01C));

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 49) == 0) step($urandom_range(0, 1) == 1, rand_byte(), 1);
         else if ($urandom_range(0, 59) == 0) idle(TMO + $urandom_range(0, 2) - 1);
         else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         else send(rand_byte());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Converts the raw PS/2 scan-code byte stream from the serial receiver into the key event interface used by the game logic: a per-key held bitmap, the most recently changed key code, and a one-cycle valid strobe.
- Handles E0 extended, F0 break and E1 pause prefixes, optional typematic-repeat suppression, an inter-byte timeout, and overrun/flush clearing.
- Sits directly between the PS/2 byte receiver and the typing/scoring block.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one multi-byte sequence before the sequence is abandoned.
- REPEAT_SUPPRESS, 1, when 1 a make code for a key already held produces no event.
- COUNT_W, 17, width of the timeout counter; must satisfy 2^COUNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received scan-code byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe, one per received byte.
- flush  input  1  synchronous request to clear all held keys.
- key_down  output  512  bit n=1 while key code n is held; n={ext,byte}.
- last_change  output  9  code of the most recent make/break event; bit 8 = E0 extended.
- key_valid  output  1  one-cycle pulse; key_down and last_change reflect the new event in the same cycle.
- seq_error  output  1  one-cycle pulse on timeout or overrun byte.

Behaviour:
- Reset (rst=0, asynchronous): key_down=0, last_change=0, key_valid=0, seq_error=0, state=IDLE, timeout counter=0, skip counter=0.
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. All transitions happen only on cycles with rx_valid=1, except timeout.
- IDLE byte decode:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - E1 -> SKIP with skip count 7.
  - FA, FE, EE, AA -> ignored, stay IDLE, no event.
  - 00 or FF (overrun) -> key_down cleared, seq_error pulse, stay IDLE.
  - Any other byte b -> make {0,b}, stay IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay GOT_E0.
  - 12 (fake shift) -> IDLE, no event.
  - Other b -> make {1,b}, IDLE.
- GOT_F0: any byte b -> break {0,b}, IDLE.
- GOT_E0F0:
  - 12 -> IDLE, no event.
  - Other b -> break {1,b}, IDLE.
- SKIP: each byte decrements the skip count; returns to IDLE after the 7th byte. No events are generated in SKIP.
- Make event: key_down[code]<=1, last_change<=code, key_valid=1 on the cycle after rx_valid (latency 1).
  - If REPEAT_SUPPRESS=1 and key_down[code] is already 1, no register change and no key_valid.
- Break event: key_down[code]<=0, last_change<=code, key_valid=1 (latency 1). A pulse is emitted even if the key was not held.
- key_valid and seq_error are never high for more than one consecutive cycle per received byte.
- Timeout:
  - The counter clears on every rx_valid and counts while state is not IDLE.
  - When it reaches TIMEOUT_CYCLES: state->IDLE, seq_error pulse, no key event, key_down unchanged.
  - The counter saturates and does not count in IDLE.
- flush=1: key_down<=0 and state->IDLE on the next edge; key_valid suppressed that cycle.
  - flush has priority over a simultaneous rx_valid; that byte is discarded.
- Back-to-back bytes (rx_valid on consecutive cycles) are each processed. The decoder accepts one byte per cycle with no stall.
- last_change holds its value between events; it is not cleared by flush or timeout.

Test Plan:
- rx bytes 1C -> key_valid pulse 1 cycle later, last_change=0x01C, key_down[0x01C]=1. Then F0,1C -> pulse, last_change=0x01C, key_down[0x01C]=0.
- 1C,1C,1C with REPEAT_SUPPRESS=1 -> exactly one key_valid. Repeat with REPEAT_SUPPRESS=0 -> three pulses.
- E0,75 -> last_change=0x175, key_down[0x175]=1. Then E0,F0,75 -> bit cleared, pulse. E0,12 -> no pulse, no bitmap change.
- E0 then idle for TIMEOUT_CYCLES -> seq_error pulse, state IDLE. A following 29 yields make 0x029, not 0x129.
- Hold 1C and 29, then send byte 00 -> key_down all zero, seq_error pulse, no key_valid. Separately, flush asserted together with rx_valid byte 1C -> key_down=0, no event.
- E1,14,77,E1,F0,14,F0,77 -> no key_valid at all. Next byte 1C -> make 0x01C. Drive rst low mid-sequence (after F0) -> all outputs zero immediately; next byte 1C after release -> make event.
